// File: rtl/fetch_decode_stage_pkg.sv
// Shared pipeline definitions for the IF/ID stage: FSM states, the NOP word,
// instruction field positions and a saturating counter helper.
package fetch_decode_stage_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0;

  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;

  localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == STALL_CNT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/fetch_decode_stage_load_use_detect.sv
// Load-use hazard equation: a load in Execute writing a register that the
// instruction in Decode names in its rs or rt field.
module fetch_decode_stage_load_use_detect (
  input  logic       valid_i,
  input  logic       load_i,
  input  logic [4:0] load_rt_i,
  input  logic [4:0] dec_rs_i,
  input  logic [4:0] dec_rt_i,
  output logic       hazard_o
);

  logic dest_nonzero;
  logic src_match;

  // rt is compared even when it is a destination; an extra stall is harmless.
  assign dest_nonzero = (load_rt_i != 5'd0);
  assign src_match    = (load_rt_i == dec_rs_i) | (load_rt_i == dec_rt_i);
  assign hazard_o     = valid_i & load_i & dest_nonzero & src_match;

endmodule

// File: rtl/fetch_decode_stage.sv
// IF/ID pipeline register with load-use stall, branch flush, global hold and
// a saturating stall-cycle counter.
module fetch_decode_stage
  import fetch_decode_stage_pkg::*;
#(
  parameter int LOAD_BUBBLES = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] instruction_i,
  input  logic [31:0] pc_plus_four_i,
  input  logic        exr_enable_i,
  input  logic [4:0]  ex_rt_i,
  input  logic        branch_taken_i,
  input  logic        hold_i,
  output logic [31:0] instruction_o,
  output logic [31:0] pc_plus_four_o,
  output logic        valid_o,
  output logic        pc_write_o,
  output logic        bubble_o,
  output logic        flush_o,
  output logic [15:0] stall_count_o,
  output state_e      state_o,
  output logic [1:0]  bub_cnt_o
);

  // Bubbles remaining after the hazard cycle and the first STALL cycle.
  localparam int          BUB_INIT_I = (LOAD_BUBBLES > 1) ? (LOAD_BUBBLES - 2) : 0;
  localparam logic [1:0]  BUB_INIT   = BUB_INIT_I[1:0];
  localparam bit          MULTI_BUB  = (LOAD_BUBBLES > 1);

  state_e      state_q;
  logic [1:0]  bub_cnt_q;
  logic [31:0] instr_q;
  logic [31:0] pc4_q;
  logic        valid_q;
  logic [15:0] stall_cnt_q;
  logic [15:0] stall_cnt_d;

  logic        hazard;
  logic        pc_write;
  logic        bubble;
  logic        flush;
  logic        do_load;
  logic        do_stall;

  fetch_decode_stage_load_use_detect u_load_use_detect (
    .valid_i   (valid_q),
    .load_i    (exr_enable_i),
    .load_rt_i (ex_rt_i),
    .dec_rs_i  (instr_q[RS_MSB:RS_LSB]),
    .dec_rt_i  (instr_q[RT_MSB:RT_LSB]),
    .hazard_o  (hazard)
  );

  always_comb begin
    pc_write = 1'b0;
    bubble   = 1'b1;
    flush    = 1'b0;
    do_load  = 1'b0;
    do_stall = 1'b0;
    if (!rst_ni) begin
      bubble = 1'b1;
    end else if (hold_i) begin
      bubble = ~valid_q;
    end else if (branch_taken_i) begin
      pc_write = 1'b1;
      flush    = 1'b1;
    end else if (state_q == STALL) begin
      do_stall = 1'b1;
    end else if (hazard) begin
      do_stall = 1'b1;
    end else begin
      do_load  = 1'b1;
      pc_write = 1'b1;
      bubble   = ~valid_q;
    end
  end

  assign stall_cnt_d = do_stall ? sat_inc16(stall_cnt_q) : stall_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= RUN;
      bub_cnt_q   <= 2'd0;
      instr_q     <= NOP_INSTR;
      pc4_q       <= 32'h0;
      valid_q     <= 1'b0;
      stall_cnt_q <= 16'h0;
    end else if (!hold_i) begin
      stall_cnt_q <= stall_cnt_d;
      if (branch_taken_i) begin
        state_q   <= RUN;
        bub_cnt_q <= 2'd0;
        instr_q   <= NOP_INSTR;
        pc4_q     <= 32'h0;
        valid_q   <= 1'b0;
      end else if (state_q == STALL) begin
        if (bub_cnt_q == 2'd0) begin
          state_q <= RUN;
        end else begin
          bub_cnt_q <= bub_cnt_q - 2'd1;
        end
      end else if (hazard) begin
        if (MULTI_BUB) begin
          state_q   <= STALL;
          bub_cnt_q <= BUB_INIT;
        end
      end else if (do_load) begin
        instr_q <= instruction_i;
        pc4_q   <= pc_plus_four_i;
        valid_q <= 1'b1;
      end
    end
  end

  assign instruction_o  = instr_q;
  assign pc_plus_four_o = pc4_q;
  assign valid_o        = valid_q;
  assign pc_write_o     = pc_write;
  assign bubble_o       = bubble;
  assign flush_o        = flush;
  assign stall_count_o  = stall_cnt_q;
  assign state_o        = state_q;
  assign bub_cnt_o      = bub_cnt_q;

endmodule

// File: doc/fetch_decode_stage.md
# fetch_decode_stage

IF/ID pipeline register with load-use hazard control, sitting directly upstream of the decode-to-execute register. Captures the fetched instruction and PC+4 each cycle. Detects a load in Execute whose destination feeds the instruction in Decode, then freezes PC and IF/ID while the decoder injects bubbles. Handles taken-branch flush and a global hold, and counts load-use stall cycles.

## Interface
- LOAD_BUBBLES, 1: number of bubble cycles inserted per load-use hazard; legal range 1..3.
- Clock  in  1  rising-edge clock.
- Reset_n  in  1  synchronous reset, active-low.
- InstructionIn  in  32  instruction word from fetch.
- PCPlusFourIn  in  32  PC+4 of that instruction.
- ExR_EnableIn  in  1  decode-to-execute register output: the instruction in Execute is a load.
- ExRtIn  in  5  destination register of that load.
- BranchTakenIn  in  1  taken branch/jump resolved downstream this cycle.
- HoldIn  in  1  global freeze (memory wait).
- InstructionOut  out  32  registered instruction presented to Decode.
- PCPlusFourOut  out  32  registered PC+4.
- ValidOut  out  1  IF/ID contents are a real instruction.
- PCWriteOut  out  1  PC may update this cycle (combinational).
- BubbleOut  out  1  decoder drives all-zero control into decode-to-execute this cycle (combinational).
- FlushOut  out  1  flush downstream pipeline registers (combinational).
- StallCountOut  out  16  saturating count of load-use stall cycles.

## Operation
- FSM states: RUN, STALL. Bubble down-counter BubCnt, 2 bits.
- hazard = ValidOut & ExR_EnableIn & (ExRtIn != 0) & ((ExRtIn == InstructionOut[25:21]) | (ExRtIn == InstructionOut[20:16])). This check is conservative: rt is compared even when it is not a source, so an occasional extra stall is acceptable.
- Cycle decisions, highest priority first:
  - Reset_n low: all registers take their reset values. PCWriteOut=0, BubbleOut=1, FlushOut=0.
  - HoldIn=1: all registers hold, including state, BubCnt and StallCountOut. PCWriteOut=0, FlushOut=0. BubbleOut=1 only if ValidOut=0; otherwise BubbleOut=0.
  - BranchTakenIn=1, in any state: InstructionOut<=0, PCPlusFourOut<=0, ValidOut<=0, state<=RUN, BubCnt<=0. PCWriteOut=1, FlushOut=1, BubbleOut=1.
  - STALL: IF/ID holds. PCWriteOut=0, BubbleOut=1, StallCountOut++.
    - If BubCnt==0, state<=RUN.
    - Otherwise BubCnt--.
    - hazard is not re-evaluated in this state.
  - RUN with hazard: IF/ID holds. PCWriteOut=0, BubbleOut=1, StallCountOut++.
    - If LOAD_BUBBLES==1, state stays RUN.
    - Otherwise state<=STALL and BubCnt<=LOAD_BUBBLES-2.
  - RUN, no hazard: InstructionOut<=InstructionIn, PCPlusFourOut<=PCPlusFourIn, ValidOut<=1. PCWriteOut=1, BubbleOut=~ValidOut.
- StallCountOut saturates at 16'hFFFF. It never wraps.

## Timing
- IF/ID latency is 1 cycle.
- Reset values: InstructionOut=0, PCPlusFourOut=0, ValidOut=0, StallCountOut=0, state=RUN, BubCnt=0.
- The first instruction is valid on the first edge after Reset_n is released.
- A load-use hazard produces exactly LOAD_BUBBLES cycles with PCWriteOut=0, independent of ExR_EnableIn after the first cycle.
- HoldIn stretches a stall; it does not consume bubble cycles.
- A branch on the same cycle as a detected hazard: the flush wins and no stall is counted.
- A branch mid-STALL aborts the remaining bubbles.

## Structure
- Shared package (pipeline package) holds:
  - state enum {RUN, STALL}
  - NOP_INSTR = 32'h0
  - field constants RS_MSB/RS_LSB = 25/21 and RT_MSB/RT_LSB = 20/16
- One natural sub-module: load_use_detect, the combinational hazard equation.

## Test plan
- Reset, then feed instr 32'h20080005 with PC+4 32'h4 -> ValidOut=1 and InstructionOut=32'h20080005 one edge later; StallCountOut=0.
- Instr in Decode 32'h01095020 (rs=8, rt=9) with ExR_EnableIn=1, ExRtIn=8, LOAD_BUBBLES=1 -> one cycle with PCWriteOut=0 and BubbleOut=1; IF/ID unchanged; StallCountOut=1.
- Same hazard with LOAD_BUBBLES=3 -> exactly 3 cycles of PCWriteOut=0; then RUN; StallCountOut=3.
- ExRtIn=0 with ExR_EnableIn=1 matching rs=0 -> no stall.
- BranchTakenIn=1 during the 2nd bubble of a 3-bubble stall -> FlushOut=1 and PCWriteOut=1; next cycle ValidOut=0, InstructionOut=0, state RUN.
- HoldIn=1 for 4 cycles in mid-stall -> outputs frozen, PCWriteOut=0, counter unchanged; the stall then completes its remaining bubbles.
- Force 65536+ stall cycles -> StallCountOut holds at 16'hFFFF.
